// File: rtl/fft_reorder_buf.sv
// fft_reorder_buf: ping-pong buffer turning a bit-reversed, word-serial FFT frame
// into natural-order {re, im} bins with valid/ready output handshake.
module fft_reorder_buf #(
    parameter int DW  = 17,
    parameter int NPT = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] re_o,
    output logic [DW-1:0] im_o,
    output logic [4:0]    idx_o,
    output logic          last_o,
    output logic          ovf_o
);
    typedef enum logic {IDLE, DRAIN} state_t;

    function automatic logic [4:0] bitrev5(input logic [4:0] x);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    logic [2*DW-1:0] mem_q [2][NPT];
    state_t          state_q, state_d;
    logic [5:0]      wcnt_q, wcnt_d;
    logic [4:0]      rcnt_q, rcnt_d;
    logic [1:0]      full_q, full_d;
    logic            wsel_q, wsel_d, rsel_q, rsel_d;
    logic            valid_q, valid_d, last_q, last_d, ovf_q, ovf_d, upd;
    logic [DW-1:0]   re_q, re_d, im_q, im_d, hold_q, hold_d;

    logic wr_ok, wr_end, take, rd_end;
    assign wr_ok  = valid_i && !full_q[wsel_q];
    assign wr_end = wr_ok && wcnt_q == 6'd63;
    assign take   = valid_q && ready_i;
    assign rd_end = state_q == DRAIN && take && rcnt_q == 5'd31;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            full_q  <= '0;
            wsel_q  <= 1'b0;
            rsel_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            full_q  <= full_d;
            wsel_q  <= wsel_d;
            rsel_q  <= rsel_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
            re_q    <= re_d;
            im_q    <= im_d;
            hold_q  <= hold_d;
        end
    end

    // Bin is written once its imaginary half arrives; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok && wcnt_q[0])
            mem_q[wsel_q][bitrev5(wcnt_q[5:1])] <= {hold_q, data_i};
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (full_q[rsel_q] ? DRAIN : IDLE)
                : (rd_end && !full_q[~rsel_q]) ? IDLE : DRAIN;
    end

    always_comb begin
        wcnt_d = wr_ok ? wcnt_q + 6'd1 : wcnt_q;
        hold_d = (wr_ok && !wcnt_q[0]) ? data_i : hold_q;
        wsel_d = wr_end ? ~wsel_q : wsel_q;
        ovf_d  = ovf_q || (valid_i && full_q[wsel_q]);
        full_d = full_q;
        if (rd_end)
            full_d[rsel_q] = 1'b0;
        if (wr_end)
            full_d[wsel_q] = 1'b1;
    end

    // Outputs reload on entry to DRAIN, on each accepted bin, and across a bank swap.
    always_comb begin
        rsel_d  = rd_end ? ~rsel_q : rsel_q;
        rcnt_d  = (state_q == IDLE) ? '0 : take ? rcnt_q + 5'd1 : rcnt_q;
        valid_d = state_d == DRAIN;
        last_d  = valid_d && rcnt_d == 5'd31;
        upd     = valid_d && (state_q == IDLE || take);
        re_d    = upd ? mem_q[rsel_d][rcnt_d][2*DW-1:DW] : re_q;
        im_d    = upd ? mem_q[rsel_d][rcnt_d][DW-1:0] : im_q;
    end

    assign valid_o = valid_q;
    assign re_o    = re_q;
    assign im_o    = im_q;
    assign idx_o   = rcnt_q;
    assign last_o  = last_q;
    assign ovf_o   = ovf_q;
endmodule

// File: tb/tb_fft_reorder_buf.sv
// tb_fft_reorder_buf: randomized frames checked against a queue of expected
// natural-order bins derived from the bit-reversed input ordering.
module tb_fft_reorder_buf;
    localparam int DW = 17;

    logic          clk = 1'b0, rst_n = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          valid_o, last_o, ovf_o;
    logic [DW-1:0] re_o, im_o;
    logic [4:0]    idx_o;

    fft_reorder_buf #(.DW(DW), .NPT(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i), .ready_i(ready_i),
        .valid_o(valid_o), .re_o(re_o), .im_o(im_o), .idx_o(idx_o), .last_o(last_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {logic [DW-1:0] re; logic [DW-1:0] im; int idx;} bin_t;
    bin_t exp_q[$];
    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int brev5(input int x);
        int r = 0;
        for (int i = 0; i < 5; i++) r = (r << 1) | ((x >> i) & 1);
        return r;
    endfunction

    // Drives nw words (ramp n=n or random); optionally queues the bins they should produce.
    task automatic feed(input bit ramp, input bit gaps, input bit expect_out, input int nw);
        logic [DW-1:0] w[64];
        for (int i = 0; i < 64; i++) w[i] = ramp ? DW'(i) : DW'($urandom);
        if (expect_out)
            for (int m = 0; m < 32; m++)
                exp_q.push_back('{w[2*brev5(m)], w[2*brev5(m)+1], m});
        for (int i = 0; i < nw; i++) begin
            if (gaps)
                while ($urandom_range(1, 0) == 1) begin
                    @(posedge clk); #1;
                end
            valid_i = 1'b1;
            data_i  = w[i];
            @(posedge clk); #1;
            valid_i = 1'b0;
        end
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_re"}, re_o, 0);
        chk({tag, "_im"}, im_o, 0);
        chk({tag, "_idx"}, idx_o, 0);
        chk({tag, "_last"}, last_o, 0);
        chk({tag, "_ovf"}, ovf_o, 0);
    endtask

    logic          prev_stall = 1'b0, p_last;
    logic [DW-1:0] p_re, p_im;
    logic [4:0]    p_idx;
    bin_t          e;

    always @(negedge clk) begin
        if (prev_stall) begin
            chk("hold_valid", valid_o, 1);
            chk("hold_re", re_o, p_re);
            chk("hold_im", im_o, p_im);
            chk("hold_idx", idx_o, p_idx);
            chk("hold_last", last_o, p_last);
        end
        if (valid_o && ready_i) begin
            if (exp_q.size() == 0) chk("extra_bin", valid_o, 0);
            else begin
                e = exp_q.pop_front();
                chk("bin_re", re_o, e.re);
                chk("bin_im", im_o, e.im);
                chk("bin_idx", idx_o, e.idx);
                chk("bin_last", last_o, e.idx == 31);
            end
        end
        prev_stall = valid_o && !ready_i && rst_n;
        p_re = re_o; p_im = im_o; p_idx = idx_o; p_last = last_o;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        // single ramp frame, latency and ordering
        ready_i = 1'b1;
        feed(1, 0, 1, 64);
        chk("lat_edge0", valid_o, 0);
        @(posedge clk); #1;
        chk("lat_edge1", valid_o, 1);
        chk("lat_idx", idx_o, 0);
        wait_empty(200);
        chk("ovf_single", ovf_o, 0);

        // random input gaps
        feed(1, 1, 1, 64);
        wait_empty(200);

        // ready pattern 1,0,0,1 while a random frame arrives
        fork
            feed(0, 0, 1, 64);
            for (int i = 0; i < 300; i++) begin
                ready_i = (i % 4 == 0) || (i % 4 == 3);
                @(posedge clk); #1;
            end
        join
        ready_i = 1'b1;
        wait_empty(200);

        // two stored frames drain without a bubble
        ready_i = 1'b0;
        feed(0, 0, 1, 64);
        feed(0, 0, 1, 64);
        ready_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            chk("b2b_valid", valid_o, 1);
            @(posedge clk); #1;
        end
        chk("b2b_end", valid_o, 0);
        wait_empty(10);

        // overflow: third frame dropped entirely
        ready_i = 1'b0;
        feed(0, 0, 1, 64);
        feed(0, 0, 1, 64);
        chk("ovf_pre", ovf_o, 0);
        feed(0, 0, 0, 1);
        chk("ovf_first", ovf_o, 1);
        feed(0, 0, 0, 63);
        chk("stall_valid", valid_o, 1);
        chk("stall_idx", idx_o, 0);
        ready_i = 1'b1;
        wait_empty(300);
        chk("ovf_sticky", ovf_o, 1);
        feed(0, 0, 1, 64);
        wait_empty(200);
        chk("ovf_sticky2", ovf_o, 1);

        // reset mid-frame, with valid_i asserted during reset
        feed(0, 0, 0, 20);
        rst_n   = 1'b0;
        valid_i = 1'b1;
        data_i  = DW'($urandom);
        @(posedge clk); #1;
        valid_i = 1'b0;
        rst_n   = 1'b1;
        chk_reset_outputs("mid_rst");
        feed(1, 0, 1, 64);
        wait_empty(200);
        chk("final_idle", valid_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fft_reorder_buf.md
FFT_REORDER_BUF -- requirements
Module: fft_reorder_buf

Interface
REQ-001 SHALL have parameter DW, default 17, width of one real or imaginary word.
REQ-002 SHALL have parameter NPT, default 32, FFT points per frame; fixed at 32 (5-bit index).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port valid_i  input  1  input word strobe; driven by the FFT core's finish output.
REQ-006 SHALL have port data_i  input  DW  input word; the FFT core's answer output.
REQ-007 SHALL have port ready_i  input  1  downstream accepts the current output bin.
REQ-008 SHALL have port valid_o  output  1  output bin valid.
REQ-009 SHALL have port re_o  output  DW  real part of the output bin.
REQ-010 SHALL have port im_o  output  DW  imaginary part of the output bin.
REQ-011 SHALL have port idx_o  output  5  natural-order bin index of the output bin.
REQ-012 SHALL have port last_o  output  1  high with the bin at idx_o=31.
REQ-013 SHALL have port ovf_o  output  1  sticky flag: an input word was dropped.

Function
REQ-014 SHALL treat the input frame as 64 valid_i words: even word = real, odd word = imaginary, pairs in bit-reversed bin order (pair k is bin bitrev5(k)).
REQ-015 SHALL count input words with a 6-bit write counter; advance only on valid_i; gaps between words are allowed.
REQ-016 SHALL hold each real word in a register and write {re,im} (2*DW bits) to the write bank at address bitrev5(wcnt[5:1]) when the imaginary word arrives.
REQ-017 SHALL use two 32-entry banks (ping-pong), each with a full flag.
REQ-018 SHALL set the write bank's full flag and toggle the write bank select in the same cycle as the 64th word is written; wcnt wraps to 0.
REQ-019 SHALL drop any valid_i word whose target bank is full, leave wcnt unchanged, and set ovf_o; ovf_o clears only on reset.
REQ-020 SHALL have a read FSM with states IDLE and DRAIN.
REQ-021 SHALL transition IDLE->DRAIN in the cycle after the read bank's full flag is seen set; rcnt=0.
REQ-022 SHALL in DRAIN present bank[rcnt] on re_o/im_o with idx_o=rcnt and valid_o=1; all outputs registered.
REQ-023 SHALL advance rcnt only on valid_o&&ready_i; outputs SHALL be held stable while valid_o&&!ready_i.
REQ-024 SHALL on acceptance of idx 31 (last_o=1) clear that bank's full flag, toggle the read bank select, and go to DRAIN if the other bank is full (no bubble), else IDLE.
REQ-025 SHALL apply a write-side full-flag set and a read-side full-flag clear on different banks in the same cycle independently; both SHALL take effect.
REQ-026 SHALL add latency of 2 cycles from the 64th input word to first valid_o (given ready_i=1).
REQ-027 SHALL sustain one bin per cycle output with ready_i=1; data SHALL be passed unmodified (no rounding or width change).

Reset
REQ-028 SHALL on rst_n=0 at a rising edge clear wcnt, rcnt, both full flags, both bank selects (bank 0), FSM to IDLE, valid_o, re_o, im_o, idx_o, last_o, ovf_o to 0.
REQ-029 SHALL not reset bank memory contents; a partial frame in progress at reset SHALL be discarded.
REQ-030 SHALL ignore valid_i in the cycle rst_n=0.

Verification
REQ-031 Single frame, word n = n (real=2k, imag=2k+1 for pair k), ready_i=1 -> 32 bins, idx_o 0..31, bin m has re_o=2*bitrev5(m), im_o=re_o+1; last_o only at idx 31; ovf_o=0.
REQ-032 Two back-to-back frames, ready_i=1 -> 64 consecutive valid_o cycles with no bubble between frames; second frame data correct.
REQ-033 ready_i toggling 1,0,0,1 repeating -> no bin lost or duplicated; outputs stable during stalls.
REQ-034 ready_i=0 throughout, three frames fed -> frames 1-2 stored, all 64 words of frame 3 dropped, ovf_o=1 from first dropped word; then ready_i=1 -> frame 1 then frame 2 emitted intact.
REQ-035 rst_n=0 for one cycle after input word 20 of a frame -> all outputs 0; a following full frame emits correctly from bank 0 with idx_o starting at 0.
REQ-036 valid_i with random gaps (50% duty) across one frame -> identical output to REQ-031.
